upsample2x: RTL and testbench
=============================

UPSAMPLE2X -- requirements
Module: upsample2x

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter IN_SIZE, default 4: input feature-map side length (>=1); OUT_SIZE = 2*IN_SIZE is derived, not a parameter.
REQ-003 SHALL have port clk  input  1: clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1: start request, sampled only in IDLE and DONE.
REQ-006 SHALL have port ifmap  input  DATA_WIDTH x IN_SIZE x IN_SIZE: input map; must be held stable from start until done.
REQ-007 SHALL have port out_data  output  DATA_WIDTH: current output pixel.
REQ-008 SHALL have port out_valid  output  1: out_data, out_row, out_col and out_last are valid.
REQ-009 SHALL have port out_ready  input  1: consumer accepts; a transfer occurs on an edge with out_valid=1 and out_ready=1.
REQ-010 SHALL have ports out_row, out_col  output  $clog2(OUT_SIZE) (min 1): coordinates of out_data.
REQ-011 SHALL have port out_last  output  1: high with pixel (OUT_SIZE-1, OUT_SIZE-1).
REQ-012 SHALL have port done  output  1: high while in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-014 IDLE with en=1 at an edge SHALL go to STREAM, load pixel (0,0) and set out_valid=1 on that edge: first pixel valid one cycle after en.
REQ-015 Output order SHALL be raster: out_col 0..OUT_SIZE-1 within out_row 0..OUT_SIZE-1.
REQ-016 Default pixel value SHALL be ifmap[out_row>>1][out_col>>1] (nearest-neighbour replication).
REQ-017 On a transfer that is not the last, counters SHALL advance, the next pixel SHALL load on the same edge, and out_valid SHALL stay 1 (no bubbles).
REQ-018 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold unchanged.
REQ-019 On the transfer with out_last=1, out_valid and out_last SHALL clear, state SHALL go to DONE, and done SHALL be 1 from that edge.
REQ-020 DONE with en=0 SHALL go to IDLE and clear done; DONE with en=1 SHALL remain in DONE (no auto-restart).
REQ-021 en in STREAM SHALL be ignored.
REQ-022 out_valid SHALL never be 1 outside STREAM; out_ready SHALL be ignored when out_valid=0.
REQ-023 IN_SIZE=1 SHALL produce exactly 4 pixels; counter wrap at OUT_SIZE-1 SHALL reset out_col to 0 and increment out_row.

Reset
REQ-024 Reset SHALL force state IDLE, counters 0, and out_data, out_valid, out_last and done to 0, at any time including mid-STREAM.
REQ-025 After reset, no partial frame SHALL resume; a new en is needed to start.

Configuration
REQ-026 Macro UPSAMPLE_ZERO_INSERT_EN defined: a pixel with out_row and out_col both even SHALL be ifmap[out_row>>1][out_col>>1]; all other pixels SHALL be 0 (transposed-conv stride-2 input).
REQ-027 Macro UPSAMPLE_ZERO_INSERT_EN undefined: REQ-016 replication SHALL apply; timing, order and handshake SHALL be identical in both builds.

Verification (IN_SIZE=2, ifmap={{1,2},{3,4}})
REQ-028 en pulse, out_ready=1 -> 16 consecutive valid cycles starting one cycle after en: 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; out_last on 16th; done=1 on the following edge.
REQ-029 out_ready=0 for 3 cycles at pixel (1,2) -> out_data=2, row=1, col=2 held for 3 cycles; the sequence then resumes unchanged, 16 transfers total.
REQ-030 UPSAMPLE_ZERO_INSERT_EN defined, out_ready=1 -> 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0.
REQ-031 reset asserted after 5 transfers -> all outputs 0 immediately; new en -> stream restarts at (0,0) with value 1.
REQ-032 en held high through DONE -> done stays 1 with no new frame; en low for 1 cycle then high -> IDLE, then a fresh 16-pixel frame.
REQ-033 en toggled during STREAM -> no effect on sequence or count.

Source files
------------

// File: rtl/upsample2x.sv
// upsample2x: 2x nearest-neighbour upsampler that streams an IN_SIZE x IN_SIZE
//   map out as a raster of OUT_SIZE x OUT_SIZE pixels, one per accepted transfer.
// Latency: first pixel is valid one cycle after en is seen in IDLE; afterwards one
//   pixel per cycle with no bubbles while out_ready is high.
// Backpressure: out_valid/out_ready handshake; every output holds while out_ready is low.
//
// Ports:
//   clk, reset          - clock (rising edge), asynchronous active-high reset
//   en                  - start request, only looked at in IDLE and DONE
//   ifmap               - input map, ifmap[row][col]; must stay stable for the frame
//   out_data/out_valid  - current output pixel and its valid flag
//   out_ready           - consumer accept
//   out_row/out_col     - coordinates of out_data
//   out_last            - marks pixel (OUT_SIZE-1, OUT_SIZE-1)
//   done                - high while the frame is finished and en has not dropped
//
// Build option: define UPSAMPLE_ZERO_INSERT_EN to emit only the even/even pixels
//   from ifmap and zeros elsewhere (stride-2 transposed-conv input). Timing, order
//   and handshake are the same in both builds.

module upsample2x #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_SIZE    = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           en,
    input  logic [IN_SIZE-1:0][IN_SIZE-1:0][DATA_WIDTH-1:0] ifmap,
    output logic [DATA_WIDTH-1:0]                          out_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [((2*IN_SIZE > 1) ? $clog2(2*IN_SIZE) : 1)-1:0] out_row,
    output logic [((2*IN_SIZE > 1) ? $clog2(2*IN_SIZE) : 1)-1:0] out_col,
    output logic                                           out_last,
    output logic                                           done
);

    localparam int OUT_SIZE = 2 * IN_SIZE;
    localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [CW-1:0] MAX_IDX = CW'(OUT_SIZE - 1);

`ifdef UPSAMPLE_ZERO_INSERT_EN
    localparam bit ZERO_INSERT = 1'b1;
`else
    localparam bit ZERO_INSERT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         row_n, col_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n, last_n, done_n;

    // Source pixel for output coordinate (r, c). The index is resolved by a
    // compare-and-select over the whole map so that non power-of-two IN_SIZE
    // values never index past the array.
    function automatic logic [DATA_WIDTH-1:0] pixel_at(input logic [CW-1:0] r,
                                                       input logic [CW-1:0] c);
        logic [CW-1:0]         ir;
        logic [CW-1:0]         ic;
        logic [DATA_WIDTH-1:0] val;
        ir  = r >> 1;
        ic  = c >> 1;
        val = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            for (int j = 0; j < IN_SIZE; j++) begin
                if (ir == CW'(i) && ic == CW'(j)) begin
                    val = ifmap[i][j];
                end
            end
        end
        // Zero-insert mode keeps only the even/even positions.
        if (ZERO_INSERT && (r[0] || c[0])) begin
            val = '0;
        end
        return val;
    endfunction

    // State and output registers. Every output is registered so nothing
    // combinational from out_ready reaches the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_row   <= '0;
            out_col   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            out_row   <= row_n;
            out_col   <= col_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic. Defaults hold every register, which
    // is exactly the stall behaviour when out_ready is low.
    always_comb begin
        state_n = state;
        row_n   = out_row;
        col_n   = out_col;
        data_n  = out_data;
        valid_n = out_valid;
        last_n  = out_last;
        done_n  = done;

        unique case (state)
            IDLE: begin
                done_n = 1'b0;
                if (en) begin
                    state_n = STREAM;
                    row_n   = '0;
                    col_n   = '0;
                    data_n  = pixel_at('0, '0);
                    valid_n = 1'b1;
                    // OUT_SIZE is at least 2, so (0,0) is never the last pixel.
                    last_n  = 1'b0;
                end
            end

            STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        // Frame complete: drop the stream and park the counters.
                        state_n = DONE;
                        row_n   = '0;
                        col_n   = '0;
                        data_n  = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        if (out_col == MAX_IDX) begin
                            col_n = '0;
                            row_n = out_row + CW'(1);
                        end else begin
                            col_n = out_col + CW'(1);
                        end
                        data_n  = pixel_at(row_n, col_n);
                        valid_n = 1'b1;
                        last_n  = (row_n == MAX_IDX) && (col_n == MAX_IDX);
                    end
                end
            end

            DONE: begin
                // No auto-restart: en must drop before another frame can begin.
                done_n = 1'b1;
                if (!en) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_upsample2x.sv
module tb_upsample2x;

    localparam int DW = 8;
    localparam int IS = 2;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           en;
    logic [IS-1:0][IS-1:0][DW-1:0]  ifmap;
    logic [DW-1:0]                  out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [1:0]                     out_row;
    logic [1:0]                     out_col;
    logic                           out_last;
    logic                           done;

    int tests  = 0;
    int failed = 0;

`ifdef UPSAMPLE_ZERO_INSERT_EN
    int exp_tab [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
`else
    int exp_tab [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
`endif

    upsample2x #(.DATA_WIDTH(DW), .IN_SIZE(IS)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ifmap     (ifmap),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects pixel 0 of a frame to be on the outputs already. Walks all 16
    // pixels, optionally stalling 3 cycles at stall_at and toggling en.
    task automatic run_frame(input bit toggle_en, input int stall_at);
        for (int k = 0; k < 16; k++) begin
            check("valid", 32'(out_valid), 32'd1);
            check("data",  32'(out_data),  32'(exp_tab[k]));
            check("row",   32'(out_row),   32'(k / 4));
            check("col",   32'(out_col),   32'(k % 4));
            check("last",  32'(out_last),  32'(k == 15));
            check("done_in_stream", 32'(done), 32'd0);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data",  32'(out_data),  32'(exp_tab[k]));
                    check("stall_row",   32'(out_row),   32'(k / 4));
                    check("stall_col",   32'(out_col),   32'(k % 4));
                end
                out_ready = 1'b1;
            end
            if (toggle_en) en = ~en;
            step();
        end
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_last",  32'(out_last),  32'd0);
        check("end_done",  32'(done),      32'd1);
    endtask

    initial begin
        ifmap[0][0] = 8'd1;
        ifmap[0][1] = 8'd2;
        ifmap[1][0] = 8'd3;
        ifmap[1][1] = 8'd4;
        reset     = 1'b1;
        en        = 1'b0;
        out_ready = 1'b1;
        #1;
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_row",   32'(out_row),   32'd0);
        check("rst_col",   32'(out_col),   32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_done",  32'(done),      32'd0);
        reset = 1'b0;
        step();
        step();
        check("idle_valid", 32'(out_valid), 32'd0);

        // Plain frame, en pulsed for one cycle.
        en = 1'b1;
        step();
        en = 1'b0;
        run_frame(1'b0, -1);

        // DONE with en low returns to IDLE.
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid2", 32'(out_valid), 32'd0);

        // Frame with a 3-cycle stall at pixel (1,2).
        en = 1'b1;
        step();
        en = 1'b0;
        run_frame(1'b0, 6);
        step();

        // Frame with en toggled throughout the stream.
        en = 1'b1;
        step();
        en = 1'b0;
        run_frame(1'b1, -1);

        // en held high through DONE: no restart.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_done",  32'(done),      32'd1);
            check("hold_valid", 32'(out_valid), 32'd0);
        end
        en = 1'b0;
        step();
        check("drop_done", 32'(done), 32'd0);
        en = 1'b1;
        step();
        en = 1'b0;
        run_frame(1'b0, -1);
        step();

        // Reset mid-stream after 5 transfers.
        en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("pre_rst_col", 32'(out_col), 32'd1);
        check("pre_rst_row", 32'(out_row), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_row",   32'(out_row),   32'd0);
        check("mid_rst_col",   32'(out_col),   32'd0);
        check("mid_rst_last",  32'(out_last),  32'd0);
        check("mid_rst_done",  32'(done),      32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_resume", 32'(out_valid), 32'd0);
        end
        en = 1'b1;
        step();
        en = 1'b0;
        check("restart_data", 32'(out_data), 32'd1);
        run_frame(1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Backstop against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

endmodule
